// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_rw;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [1:0]        dm_size;
    logic              dm_gnt;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_size;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_rw, dm_addr, dm_wdata, dm_size, mem_rdata,
        output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
        output mem_en, mem_rw, mem_addr, mem_wdata, mem_size
    );

    modport master (
        output if_req, if_addr, dm_req, dm_rw, dm_addr, dm_wdata, dm_size, mem_rdata,
        input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
        input  mem_en, mem_rw, mem_addr, mem_wdata, mem_size
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one fixed-latency memory, data priority with starvation guard
// Optional MEM_ARB_PERF_EN adds perf_if_wait, perf_dm_wait and perf_busy counters.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clock,
    input  logic        reset,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0] perf_if_wait,
    output logic [31:0] perf_dm_wait,
    output logic [31:0] perf_busy,
`endif
    mem_arbiter_if.slave bus
);
    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t            state;
    logic [3:0]        lat_cnt;
    logic [3:0]        starve_cnt;
    logic              if_valid_q;
    logic              dm_valid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              arb_ok;
    logic              if_win;
    logic              dm_win;
    logic              dm_load_done;
    logic [ADDR_W-1:0] win_addr;

    // Arbitration also runs in the completion cycle so a new issue lands right after valid.
    assign arb_ok       = (state == IDLE) || (lat_cnt == 4'd0);
    assign if_win       = arb_ok && bus.if_req && (!bus.dm_req || starve_cnt == STARVE_LIM);
    assign dm_win       = arb_ok && bus.dm_req && !if_win;
    assign win_addr     = if_win ? bus.if_addr : bus.dm_addr;
    assign dm_load_done = dm_valid_q && !bus.mem_rw;

    // Memory data arrives in the valid cycle itself; it is passed through then and held afterwards.
    assign bus.if_valid = if_valid_q;
    assign bus.dm_valid = dm_valid_q;
    assign bus.if_rdata = if_valid_q   ? bus.mem_rdata : if_rdata_q;
    assign bus.dm_rdata = dm_load_done ? bus.mem_rdata : dm_rdata_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            starve_cnt    <= '0;
            if_valid_q    <= 1'b0;
            dm_valid_q    <= 1'b0;
            if_rdata_q    <= '0;
            dm_rdata_q    <= '0;
            bus.if_gnt    <= 1'b0;
            bus.dm_gnt    <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_rw    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_size  <= '0;
        end else begin
            bus.if_gnt <= if_win;
            bus.dm_gnt <= dm_win;
            bus.mem_en <= if_win || dm_win;
            if_valid_q <= (state == BUSY_IF) && (lat_cnt == 4'd1);
            dm_valid_q <= (state == BUSY_DM) && (lat_cnt == 4'd1);
            if (if_valid_q)
                if_rdata_q <= bus.mem_rdata;
            if (dm_load_done)
                dm_rdata_q <= bus.mem_rdata;
            if (lat_cnt != 4'd0)
                lat_cnt <= lat_cnt - 4'd1;

            if (if_win || dm_win) begin
                state        <= if_win ? BUSY_IF : BUSY_DM;
                lat_cnt      <= LAT_INIT;
                bus.mem_addr <= win_addr;
                bus.mem_rw   <= dm_win && bus.dm_rw;
                bus.mem_size <= if_win ? 2'd2 : bus.dm_size;
                if (dm_win)
                    bus.mem_wdata <= bus.dm_wdata;
                if (if_win)
                    starve_cnt <= '0;
                else if (bus.if_req && starve_cnt != STARVE_LIM)
                    starve_cnt <= starve_cnt + 4'd1;
            end else if (arb_ok) begin
                state <= IDLE;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_if_wait <= '0;
            perf_dm_wait <= '0;
            perf_busy    <= '0;
        end else begin
            if (bus.if_req && !bus.if_gnt)
                perf_if_wait <= perf_if_wait + 32'd1;
            if (bus.dm_req && !bus.dm_gnt)
                perf_dm_wait <= perf_dm_wait + 32'd1;
            if (state != IDLE)
                perf_busy <= perf_busy + 32'd1;
        end
    end
`endif
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port, fixed-latency unified memory between the fetch port (instruction reads) and the memory-stage port (data loads and stores). Only one transaction is outstanding at a time. The data port has priority; a starvation counter forces a fetch grant after a bounded number of data wins. Sits between the PC/fetch stage, the memory stage and the backing memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from issue to read data / write completion; legal range 1..15
STARVE_MAX, 4, consecutive data wins over a pending fetch before fetch is forced; legal range 1..15

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse: fetch issued to memory
if_valid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched instruction
dm_req  in  1  data request; held until dm_gnt
dm_rw  in  1  0 = read, 1 = write
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_size  in  2  access size: 0 = byte, 1 = half, 2 = word
dm_gnt  out  1  one-cycle pulse: data access issued
dm_valid  out  1  one-cycle pulse: load data valid, or store complete
dm_rdata  out  DATA_W  load data, raw (unextended)
mem_en  out  1  one-cycle issue strobe to memory
mem_rw  out  1  0 = read, 1 = write
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched store data
mem_size  out  2  latched access size
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_DM. A 4-bit latency counter lat_cnt and a starvation counter starve_cnt (saturating at STARVE_MAX).
- In IDLE, at a clock edge with any request sampled:
  - Fetch wins if if_req=1 and (dm_req=0 or starve_cnt==STARVE_MAX). Otherwise data wins.
  - Go to BUSY_IF or BUSY_DM and latch the address, rw, wdata and size into the mem_* registers. Fetch is latched as rw=0, size=2.
  - Assert the winner's gnt and mem_en for exactly that next cycle (cycle E). Load lat_cnt=MEM_LAT.
- Busy states: lat_cnt decrements every cycle after E. In cycle E+MEM_LAT:
  - Owner's valid=1.
  - Owner's rdata = mem_rdata, registered onto the output so it stays stable until the next valid for that port.
  - The FSM returns to IDLE at the following edge.
- Requests are not sampled while busy. The earliest next issue is E+MEM_LAT+1, so throughput is one transaction per MEM_LAT+1 cycles.
- mem_addr, mem_rw, mem_wdata and mem_size hold their latched values until the next issue. mem_en is high only in cycle E.
- starve_cnt:
  - Increments (saturating) when data wins while if_req=1.
  - Clears when fetch wins.
  - Unchanged when data wins with if_req=0.
- Writes: dm_valid pulses at E+MEM_LAT as the completion ack; dm_rdata is unchanged.
- Requester contract: after gnt, the requester may drop req or change its address. Re-asserting req in the valid cycle is a new request.
- Reset (async, reset=0), including mid-transaction:
  - FSM=IDLE, counters=0.
  - All outputs 0: gnt, valid, mem_en, mem_rw, mem_addr, mem_wdata, mem_size, rdata.
  - Any in-flight transaction is dropped; no valid is ever produced for it.
- Simultaneous dm_req and if_req with starve_cnt<STARVE_MAX: data wins.
- dm_size=3 is passed through unchanged; it is not checked.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: adds outputs perf_if_wait[31:0], perf_dm_wait[31:0] and perf_busy[31:0].
  - perf_if_wait / perf_dm_wait: cycles with req=1 and no gnt for that port.
  - perf_busy: cycles not in IDLE.
  - All three wrap modulo 2^32 and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- MEM_LAT=2. Single fetch: if_req=1, if_addr=0x01000000, mem_rdata=0x00500093 at E+2 -> if_gnt in cycle E, mem_en=1 with mem_addr=0x01000000 in cycle E, if_valid at E+2, if_rdata=0x00500093.
- Store then load: dm store to 0x01000010 with 0xDEADBEEF, size 2 -> dm_gnt, mem_rw=1, dm_valid at E+2. The next load issues at E+3 with mem_rw=0.
- Contention, STARVE_MAX=4: if_req and dm_req both held continuously -> grant order DM, DM, DM, DM, IF, DM…; starve_cnt clears after the IF grant.
- Async reset asserted at E+1 of a load -> all outputs 0 immediately. No dm_valid follows. After release, the held dm_req is granted on the first edge.
- Back-to-back fetches: if_req held with 4 addresses -> if_gnt spacing is exactly 3 cycles; each if_valid carries the matching data.
- With MEM_ARB_PERF_EN defined: repeat the contention test for 20 cycles -> perf_busy and perf_if_wait match a scoreboard count exactly.
